// File: rtl/bus_control_unit.sv
// bus_control_unit: hardwired control sequencer for the single-bus CPU datapath.
// Fetches an instruction, then steps through the execute sequence for its opcode,
// driving bus-out selects, register load enables, ALU op and memory strobes.
// Optional macro RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
module bus_control_unit #(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        mem_ready,
   output logic        PCout,
   output logic        ZHIout,
   output logic        ZLOout,
   output logic        MDRout,
   output logic        Cout,
   output logic        Rout,
   output logic        BAout,
   output logic        PCin,
   output logic        MARin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        Zlowin,
   output logic        Zhighin,
   output logic        HIin,
   output logic        LOin,
   output logic        Rin,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        IncPC,
   output logic        read,
   output logic        write,
   output logic [4:0]  operation,
   output logic        halted,
   output logic        illegal
`ifdef RETIRE_CNT_EN
   ,
   output logic [31:0] retire_count
`endif
);

   localparam int unsigned CNT_W = 32;

   typedef enum logic [3:0] {
      S_F0, S_F1, S_F2, S_F3, S_E0, S_E1, S_E2, S_E3, S_E4, S_HALT
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic               illegal_q, ill_set;

   logic [4:0] opc, alu_op;
   logic       is_ld, is_ldi, is_st, is_reg, is_imm, is_md, is_nn;
   logic       is_nop, is_halt, is_legal;
   logic       in_wait, timeout;
   logic       unused_ir;

   assign opc       = IR[31:27];
   assign unused_ir = ^IR[26:0];

   // Opcode class decode and ALU code mapping
   always_comb begin
      is_ld    = (opc == 5'b00000);
      is_ldi   = (opc == 5'b00001);
      is_st    = (opc == 5'b00010);
      is_reg   = (opc >= 5'b00011) && (opc <= 5'b01010);
      is_imm   = (opc >= 5'b01011) && (opc <= 5'b01101);
      is_md    = (opc == 5'b01110) || (opc == 5'b01111);
      is_nn    = (opc == 5'b10000) || (opc == 5'b10001);
      is_nop   = (opc == 5'b11000);
      is_halt  = (opc == 5'b11001);
      is_legal = (opc <= 5'b10001) || is_nop || is_halt;
      case (opc)
         5'b00000, 5'b00001, 5'b00010, 5'b01011: alu_op = 5'b00011;
         5'b01100:                               alu_op = 5'b00100;
         5'b01101:                               alu_op = 5'b00110;
         default:                                alu_op = opc;
      endcase
   end

   // Memory wait states and the timeout condition (limit cycle with ready=1 completes)
   assign in_wait = (state_q == S_F2) || ((state_q == S_E3) && is_ld) ||
                    ((state_q == S_E4) && is_st);
   assign timeout = in_wait && !mem_ready && (MEM_WAIT_MAX != 0) &&
                    ((wait_cnt_q + CNT_W'(1)) == CNT_W'(MEM_WAIT_MAX));

   // State register plus wait counter and sticky illegal flag
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q    <= S_F0;
         wait_cnt_q <= '0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         illegal_q  <= illegal_q | ill_set;
      end
   end

   // Next-state sequencing per opcode class
   always_comb begin
      state_d = state_q;
      ill_set = 1'b0;
      if (timeout) begin
         state_d = S_HALT;
         ill_set = 1'b1;
      end else begin
         case (state_q)
            S_F0:   state_d = S_F1;
            S_F1:   state_d = S_F2;
            S_F2:   state_d = mem_ready ? S_F3 : S_F2;
            S_F3: begin
               if (is_nop)         state_d = S_F0;
               else if (is_halt)   state_d = S_HALT;
               else if (!is_legal) begin
                  state_d = S_HALT;
                  ill_set = 1'b1;
               end else            state_d = S_E0;
            end
            S_E0:   state_d = S_E1;
            S_E1:   state_d = is_nn ? S_F0 : S_E2;
            S_E2:   state_d = (is_reg || is_imm || is_ldi) ? S_F0 : S_E3;
            S_E3: begin
               if (is_md)      state_d = S_F0;
               else if (is_ld) state_d = mem_ready ? S_E4 : S_E3;
               else            state_d = S_E4;
            end
            S_E4: begin
               if (is_ld) state_d = S_F0;
               else       state_d = mem_ready ? S_F0 : S_E4;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_F0;
         endcase
      end
      wait_cnt_d = (in_wait && (state_d == state_q)) ? wait_cnt_q + CNT_W'(1) : '0;
   end

   // Moore output decode from state and IR; everything forced low while clear is held
   always_comb begin
      {PCout, ZHIout, ZLOout, MDRout, Cout, Rout, BAout} = '0;
      {PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, Rin} = '0;
      {Gra, Grb, Grc, IncPC, read, write} = '0;
      operation = 5'b00000;
      halted    = 1'b0;
      illegal   = 1'b0;
      if (clear) begin
         case (state_q)
            S_F0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
            S_F1: begin ZLOout = 1'b1; PCin = 1'b1; end
            S_F2: begin read = 1'b1; MDRin = 1'b1; end
            S_F3: begin MDRout = 1'b1; IRin = 1'b1; end
            S_E0: begin
               if (is_nn) begin
                  Grb = 1'b1; Rout = 1'b1; operation = alu_op; Zlowin = 1'b1;
               end else if (is_md) begin
                  Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
               end else if (is_ld || is_ldi || is_st) begin
                  Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
               end else begin
                  Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
               end
            end
            S_E1: begin
               if (is_nn) begin
                  ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end else if (is_md) begin
                  Grb = 1'b1; Rout = 1'b1; operation = alu_op;
                  Zlowin = 1'b1; Zhighin = 1'b1;
               end else if (is_reg) begin
                  Grc = 1'b1; Rout = 1'b1; operation = alu_op; Zlowin = 1'b1;
               end else begin
                  Cout = 1'b1; operation = alu_op; Zlowin = 1'b1;
               end
            end
            S_E2: begin
               ZLOout = 1'b1;
               if (is_md)               LOin = 1'b1;
               else if (is_ld || is_st) MARin = 1'b1;
               else begin Gra = 1'b1; Rin = 1'b1; end
            end
            S_E3: begin
               if (is_md)      begin ZHIout = 1'b1; HIin = 1'b1; end
               else if (is_ld) begin read = 1'b1; MDRin = 1'b1; end
               else            begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            end
            S_E4: begin
               if (is_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               else       write = 1'b1;
            end
            S_HALT: begin
               halted  = 1'b1;
               illegal = illegal_q;
            end
            default: ;
         endcase
      end
   end

`ifdef RETIRE_CNT_EN
   logic [31:0] retire_q;

   // Count instructions completing into F0; halt paths never reach F0
   always_ff @(posedge clock or negedge clear) begin
      if (!clear)                 retire_q <= '0;
      else if (state_d == S_F0)   retire_q <= retire_q + 32'd1;
   end

   assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_bus_control_unit.sv
// Self-checking bench for bus_control_unit: randomized instruction stream and
// memory wait patterns checked each cycle against a step-list reference model.
`timescale 1ns/1ps
module tb_bus_control_unit;

   localparam int unsigned TB_WAIT_MAX = 15;

   localparam logic [22:0] C_PCOUT   = 23'd1 << 0;
   localparam logic [22:0] C_ZHIOUT  = 23'd1 << 1;
   localparam logic [22:0] C_ZLOOUT  = 23'd1 << 2;
   localparam logic [22:0] C_MDROUT  = 23'd1 << 3;
   localparam logic [22:0] C_COUT    = 23'd1 << 4;
   localparam logic [22:0] C_ROUT    = 23'd1 << 5;
   localparam logic [22:0] C_BAOUT   = 23'd1 << 6;
   localparam logic [22:0] C_PCIN    = 23'd1 << 7;
   localparam logic [22:0] C_MARIN   = 23'd1 << 8;
   localparam logic [22:0] C_MDRIN   = 23'd1 << 9;
   localparam logic [22:0] C_IRIN    = 23'd1 << 10;
   localparam logic [22:0] C_YIN     = 23'd1 << 11;
   localparam logic [22:0] C_ZLOWIN  = 23'd1 << 12;
   localparam logic [22:0] C_ZHIGHIN = 23'd1 << 13;
   localparam logic [22:0] C_HIIN    = 23'd1 << 14;
   localparam logic [22:0] C_LOIN    = 23'd1 << 15;
   localparam logic [22:0] C_RIN     = 23'd1 << 16;
   localparam logic [22:0] C_GRA     = 23'd1 << 17;
   localparam logic [22:0] C_GRB     = 23'd1 << 18;
   localparam logic [22:0] C_GRC     = 23'd1 << 19;
   localparam logic [22:0] C_INCPC   = 23'd1 << 20;
   localparam logic [22:0] C_READ    = 23'd1 << 21;
   localparam logic [22:0] C_WRITE   = 23'd1 << 22;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] IR;
   logic        mem_ready;
   logic PCout, ZHIout, ZLOout, MDRout, Cout, Rout, BAout;
   logic PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, Rin;
   logic Gra, Grb, Grc, IncPC, read, write;
   logic [4:0] operation;
   logic halted, illegal;
`ifdef RETIRE_CNT_EN
   logic [31:0] retire_count;
`endif

   bus_control_unit #(.MEM_WAIT_MAX(TB_WAIT_MAX)) dut (
      .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
      .PCout(PCout), .ZHIout(ZHIout), .ZLOout(ZLOout), .MDRout(MDRout),
      .Cout(Cout), .Rout(Rout), .BAout(BAout),
      .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin), .Rin(Rin),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .read(read), .write(write),
      .operation(operation), .halted(halted), .illegal(illegal)
`ifdef RETIRE_CNT_EN
      , .retire_count(retire_count)
`endif
   );

   always #5 clock = ~clock;

   logic [22:0] ctl;
   assign ctl = {write, read, IncPC, Grc, Grb, Gra, Rin, LOin, HIin, Zhighin, Zlowin,
                 Yin, IRin, MDRin, MARin, PCin, BAout, Rout, Cout, MDRout, ZLOout,
                 ZHIout, PCout};

   typedef struct packed {
      logic [22:0] c;
      logic [4:0]  op;
      logic        wt;
   } step_t;

   step_t       exp_q[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] ret_model = 32'd0;
   logic [31:0] ir_pending;
   bit          ir_load = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock: drive mem_ready after the falling edge, then compare all outputs
   task automatic cyc(input string tag, input logic [22:0] c, input logic [4:0] op,
                      input logic h, input logic il, input logic mr);
      @(negedge clock);
      if (ir_load) begin
         IR      = ir_pending;
         ir_load = 1'b0;
      end
      mem_ready = mr;
      #1;
      check(tag, {2'b00, halted, illegal, operation, ctl}, {2'b00, h, il, op, c});
`ifdef RETIRE_CNT_EN
      check({tag, "/retire"}, retire_count, ret_model);
`endif
   endtask

   function automatic void push(input logic [22:0] c, input logic [4:0] op, input logic wt);
      step_t s;
      s.c  = c;
      s.op = op;
      s.wt = wt;
      exp_q.push_back(s);
   endfunction

   function automatic logic [4:0] alu_ref(input int o);
      if (o == 0 || o == 1 || o == 2 || o == 11) return 5'd3;
      if (o == 12) return 5'd4;
      if (o == 13) return 5'd6;
      return 5'(o);
   endfunction

   function automatic bit legal_ref(input int o);
      return (o <= 17) || (o == 24) || (o == 25);
   endfunction

   // Reference step list for one instruction, written from the opcode tables
   function automatic void build_seq(input int o);
      logic [4:0] a;
      a = alu_ref(o);
      exp_q.delete();
      push(C_PCOUT | C_MARIN | C_INCPC | C_ZLOWIN, 5'd0, 1'b0);
      push(C_ZLOOUT | C_PCIN, 5'd0, 1'b0);
      push(C_READ | C_MDRIN, 5'd0, 1'b1);
      push(C_MDROUT | C_IRIN, 5'd0, 1'b0);
      if (o >= 3 && o <= 10) begin
         push(C_GRB | C_ROUT | C_YIN, 5'd0, 1'b0);
         push(C_GRC | C_ROUT | C_ZLOWIN, a, 1'b0);
         push(C_ZLOOUT | C_GRA | C_RIN, 5'd0, 1'b0);
      end else if (o >= 11 && o <= 13) begin
         push(C_GRB | C_ROUT | C_YIN, 5'd0, 1'b0);
         push(C_COUT | C_ZLOWIN, a, 1'b0);
         push(C_ZLOOUT | C_GRA | C_RIN, 5'd0, 1'b0);
      end else if (o == 14 || o == 15) begin
         push(C_GRA | C_ROUT | C_YIN, 5'd0, 1'b0);
         push(C_GRB | C_ROUT | C_ZLOWIN | C_ZHIGHIN, a, 1'b0);
         push(C_ZLOOUT | C_LOIN, 5'd0, 1'b0);
         push(C_ZHIOUT | C_HIIN, 5'd0, 1'b0);
      end else if (o == 16 || o == 17) begin
         push(C_GRB | C_ROUT | C_ZLOWIN, a, 1'b0);
         push(C_ZLOOUT | C_GRA | C_RIN, 5'd0, 1'b0);
      end else if (o <= 2) begin
         push(C_GRB | C_BAOUT | C_YIN, 5'd0, 1'b0);
         push(C_COUT | C_ZLOWIN, a, 1'b0);
         if (o == 1) begin
            push(C_ZLOOUT | C_GRA | C_RIN, 5'd0, 1'b0);
         end else begin
            push(C_ZLOOUT | C_MARIN, 5'd0, 1'b0);
            if (o == 0) begin
               push(C_READ | C_MDRIN, 5'd0, 1'b1);
               push(C_MDROUT | C_GRA | C_RIN, 5'd0, 1'b0);
            end else begin
               push(C_GRA | C_ROUT | C_MDRIN, 5'd0, 1'b0);
               push(C_WRITE, 5'd0, 1'b1);
            end
         end
      end
   endfunction

   // Run one instruction; tmo_at selects which wait step (1=fetch, 2=execute) times out
   task automatic run_instr(input logic [31:0] ir, input int f2_w, input int mem_w,
                            input int tmo_at);
      int    o, wi, n;
      bit    stop;
      logic  hexp, iexp;
      string tag;
      o          = int'(ir[31:27]);
      ir_pending = ir;
      ir_load    = 1'b1;
      build_seq(o);
      wi   = 0;
      stop = 1'b0;
      foreach (exp_q[i]) begin
         if (stop) break;
         tag = $sformatf("ir=%h step%0d", ir, i);
         if (exp_q[i].wt) begin
            wi++;
            if (wi == tmo_at) begin
               repeat (TB_WAIT_MAX) cyc(tag, exp_q[i].c, exp_q[i].op, 1'b0, 1'b0, 1'b0);
               stop = 1'b1;
            end else begin
               n = (wi == 1) ? f2_w : mem_w;
               repeat (n) cyc(tag, exp_q[i].c, exp_q[i].op, 1'b0, 1'b0, 1'b0);
               cyc(tag, exp_q[i].c, exp_q[i].op, 1'b0, 1'b0, 1'b1);
            end
         end else begin
            cyc(tag, exp_q[i].c, exp_q[i].op, 1'b0, 1'b0, 1'($urandom));
         end
      end
      hexp = stop || (o == 25) || !legal_ref(o);
      iexp = stop || !legal_ref(o);
      if (hexp) begin
         repeat (20) cyc($sformatf("ir=%h halted", ir), 23'd0, 5'd0, 1'b1, iexp,
                         1'($urandom));
      end else begin
         ret_model = ret_model + 32'd1;
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      clear     = 1'b0;
      mem_ready = 1'($urandom);
      #1;
      ret_model = 32'd0;
      check("in_clear", {2'b00, halted, illegal, operation, ctl}, 32'd0);
      @(posedge clock);
      #2 clear = 1'b1;
   endtask

   initial begin
      int ops[19] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 24};
      int o;
      clear     = 1'b0;
      IR        = 32'd0;
      mem_ready = 1'b0;
      repeat (2) @(negedge clock);
      do_reset();

      // Directed: and, add with fetch waits, mul, ld/st at the wait limit
      run_instr(32'h2022_8000, 0, 0, 0);
      run_instr(32'h1800_0000 | 32'($urandom_range(0, 32'h07FF_FFFF)), 3, 0, 0);
      run_instr(32'h7118_0000, 0, 0, 0);
      run_instr(32'h0080_0005, 14, 14, 0);
      run_instr(32'h1080_0007, 2, 14, 0);

      // Randomized legal, non-halting instruction stream
      for (int k = 0; k < 40; k++) begin
         o = ops[$urandom_range(0, 18)];
         run_instr({5'(o), 27'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end

      // Clear pulsed during F2 drops read without an edge
      ir_pending = 32'h1800_0000;
      ir_load    = 1'b1;
      cyc("pre_clr F0", C_PCOUT | C_MARIN | C_INCPC | C_ZLOWIN, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc("pre_clr F1", C_ZLOOUT | C_PCIN, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc("pre_clr F2", C_READ | C_MDRIN, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 clear = 1'b0;
      #1;
      ret_model = 32'd0;
      check("async_clear", {2'b00, halted, illegal, operation, ctl}, 32'd0);
      @(posedge clock);
      #2 clear = 1'b1;
      run_instr(32'h4000_0000, 0, 0, 0);

      // halt and undefined opcodes
      run_instr(32'hC800_0000, 0, 0, 0);
      do_reset();
      run_instr(32'hF800_0000, 1, 0, 0);
      do_reset();
      run_instr(32'h9000_0000, 0, 0, 0);
      do_reset();
      run_instr(32'hD000_0000, 0, 0, 0);
      do_reset();

      // Memory timeouts in fetch and in ld execute
      run_instr(32'h1800_0000, 0, 0, 1);
      do_reset();
      run_instr(32'h0000_0000, 0, 0, 2);
      do_reset();
      run_instr(32'h1000_0000, 0, 0, 2);
      do_reset();

      // Retire sequence: add, nop, ld, then halt
      run_instr(32'h1812_0000, 0, 0, 0);
      run_instr(32'hC000_0000, 1, 0, 0);
      run_instr(32'h0080_0000, 0, 2, 0);
      run_instr(32'hC800_0000, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
